// File: rtl/eth_tx_arbiter.sv
// Purpose: round-robin arbiter merging two requester byte streams into one TX stream, enforcing an inter-frame gap.
// Latency: grant is registered one cycle after a request is seen in IDLE; the byte path is combinational while granted.
// Backpressure: tx_ready passes straight to the granted requester; ungranted requesters always see ready=0.
module eth_tx_arbiter #(
    parameter int IFG_CYCLES      = 48,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_last,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       overflow_err
);

    // Gap counter only has to hold IFG_CYCLES-1.
    localparam int               GAP_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(IFG_CYCLES - 1);
    localparam logic [10:0]      MAX_BYTES = 11'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t           state_q;
    logic [1:0]       grant_q;
    logic             last_srv_q;   // 1 when req1 was the most recently granted requester
    logic [10:0]      byte_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             ovf_q;
    logic             busy_q;

    logic             sel_valid;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic [10:0]      byte_cnt_d;
    logic             hit_max;
    logic             in_xfer;
    logic             in_drain;
    logic             sel_ready;
    logic             tx_hs;
    logic             pick1_d;

    // Mux the granted requester onto the internal selected stream.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 8'h00;
        sel_last  = 1'b0;
        if (grant_q[1]) begin
            sel_valid = req1_valid;
            sel_data  = req1_data;
            sel_last  = req1_last;
        end else if (grant_q[0]) begin
            sel_valid = req0_valid;
            sel_data  = req0_data;
            sel_last  = req0_last;
        end
    end

    // Choose the next owner: a lone requester wins, on contention the one not served last wins.
    always_comb begin
        pick1_d = 1'b0;
        if (req0_valid && req1_valid) begin
            pick1_d = ~last_srv_q;
        end else begin
            pick1_d = req1_valid;
        end
    end

    // Byte count after the current handshake; reaching the limit without last truncates the frame.
    assign byte_cnt_d = byte_cnt_q + 11'd1;
    assign hit_max    = (byte_cnt_d == MAX_BYTES);

    // Reset gates the combinational outputs so no byte is accepted in the reset cycle.
    assign in_xfer    = (state_q == ST_XFER) && !reset;
    assign in_drain   = (state_q == ST_DRAIN) && !reset;

    assign tx_valid   = in_xfer && sel_valid;
    assign tx_data    = in_xfer ? sel_data : 8'h00;
    assign tx_last    = tx_valid && (sel_last || hit_max);
    assign tx_hs      = tx_valid && tx_ready;

    // While draining a truncated frame the owner is always ready so its tail is discarded.
    assign sel_ready  = (in_xfer && tx_ready) || in_drain;
    assign req0_ready = sel_ready && grant_q[0];
    assign req1_ready = sel_ready && grant_q[1];

    assign grant        = grant_q;
    assign busy         = busy_q;
    assign overflow_err = ovf_q;

    // Arbitration FSM with registered grant, busy, overflow pulse and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            last_srv_q <= 1'b1;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        state_q    <= ST_XFER;
                        grant_q    <= pick1_d ? 2'b10 : 2'b01;
                        last_srv_q <= pick1_d;
                        byte_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (tx_hs) begin
                        byte_cnt_q <= byte_cnt_d;
                        if (sel_last) begin
                            state_q   <= ST_GAP;
                            grant_q   <= 2'b00;
                            gap_cnt_q <= GAP_LOAD;
                        end else if (hit_max) begin
                            state_q <= ST_DRAIN;
                            ovf_q   <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sel_valid && sel_last) begin
                        state_q   <= ST_GAP;
                        grant_q   <= 2'b00;
                        gap_cnt_q <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: a default instance plus a MAX_FRAME_BYTES=4 instance sharing the same inputs.
// Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
// Requesters are modelled as byte queues popped whenever valid&ready was seen before the rising edge.
module tb_eth_tx_arbiter;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req1_valid, req0_last, req1_last, tx_ready;

    logic       a_r0, a_r1, a_txv, a_txl, a_busy, a_ovf;
    logic [7:0] a_txd;
    logic [1:0] a_grant;
    logic       b_r0, b_r1, b_txv, b_txl, b_busy, b_ovf;
    logic [7:0] b_txd;
    logic [1:0] b_grant;

    eth_tx_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(a_r0),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(a_r1),
        .tx_data(a_txd), .tx_valid(a_txv), .tx_last(a_txl), .tx_ready(tx_ready),
        .grant(a_grant), .busy(a_busy), .overflow_err(a_ovf)
    );

    eth_tx_arbiter #(.IFG_CYCLES(48), .MAX_FRAME_BYTES(4)) dut_m4 (
        .clk(clk), .reset(reset),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(b_r0),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(b_r1),
        .tx_data(b_txd), .tx_valid(b_txv), .tx_last(b_txl), .tx_ready(tx_ready),
        .grant(b_grant), .busy(b_busy), .overflow_err(b_ovf)
    );

    // Observed outputs come from whichever instance the current sequence targets.
    logic       sel_m4;
    logic       o_r0, o_r1, o_txv, o_txl, o_busy, o_ovf;
    logic [7:0] o_txd;
    logic [1:0] o_grant;
    assign o_r0    = sel_m4 ? b_r0    : a_r0;
    assign o_r1    = sel_m4 ? b_r1    : a_r1;
    assign o_txv   = sel_m4 ? b_txv   : a_txv;
    assign o_txl   = sel_m4 ? b_txl   : a_txl;
    assign o_busy  = sel_m4 ? b_busy  : a_busy;
    assign o_ovf   = sel_m4 ? b_ovf   : a_ovf;
    assign o_txd   = sel_m4 ? b_txd   : a_txd;
    assign o_grant = sel_m4 ? b_grant : a_grant;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       txr;
        logic [1:0] grant;
        logic       busy;
        logic       txv;
        logic [7:0] txd;
        logic       txl;
        logic       r0;
        logic       r1;
        logic       ovf;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic v0, input logic [7:0] d0, input logic l0,
                                input logic v1, input logic [7:0] d1, input logic l1, input logic txr,
                                input logic [1:0] g, input logic bsy, input logic txv, input logic [7:0] txd,
                                input logic txl, input logic r0, input logic r1, input logic ovf);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1; v.txr = txr;
        v.grant = g; v.busy = bsy; v.txv = txv; v.txd = txd; v.txl = txl; v.r0 = r0; v.r1 = r1; v.ovf = ovf;
        return v;
    endfunction

    // Requester queues and sequence bookkeeping.
    logic [7:0] q0d[$], q1d[$], capd[$];
    logic       q0l[$], q1l[$], capl[$];
    logic [1:0] gh[$];
    int         gt[$];
    logic       en0, en1, rst_drv, txr_toggle, hs0, hs1;
    logic [1:0] prev_grant;
    int         tick_n = 0;
    int         busy_cnt, ovf_cnt, ovf_tick, last_tx_tick, viol;

    task automatic tick_a();
        reset      = rst_drv;
        req0_valid = en0 && (q0d.size() > 0);
        req0_data  = req0_valid ? q0d[0] : 8'h00;
        req0_last  = req0_valid ? q0l[0] : 1'b0;
        req1_valid = en1 && (q1d.size() > 0);
        req1_data  = req1_valid ? q1d[0] : 8'h00;
        req1_last  = req1_valid ? q1l[0] : 1'b0;
        tx_ready   = txr_toggle ? tick_n[0] : 1'b1;
        #1;
        hs0 = req0_valid && o_r0;
        hs1 = req1_valid && o_r1;
        if (o_txv && tx_ready) begin
            capd.push_back(o_txd);
            capl.push_back(o_txl);
            last_tx_tick = tick_n;
        end
        if (o_ovf) begin
            ovf_cnt++;
            ovf_tick = tick_n;
        end
        if (o_busy) busy_cnt++;
        if (o_grant != 2'b00 && prev_grant == 2'b00) begin
            gh.push_back(o_grant);
            gt.push_back(tick_n);
        end
        prev_grant = o_grant;
        if (o_r0 && o_grant != 2'b01) viol++;
        if (o_r1 && o_grant != 2'b10) viol++;
        if (o_txv && ((o_r0 | o_r1) != tx_ready)) viol++;
    endtask

    task automatic tick_b();
        @(negedge clk);
        if (hs0) begin void'(q0d.pop_front()); void'(q0l.pop_front()); end
        if (hs1) begin void'(q1d.pop_front()); void'(q1l.pop_front()); end
        tick_n++;
    endtask

    task automatic tick();
        tick_a();
        tick_b();
    endtask

    task automatic do_reset();
        rst_drv = 1'b1; en0 = 1'b0; en1 = 1'b0; txr_toggle = 1'b0;
        q0d.delete(); q0l.delete(); q1d.delete(); q1l.delete();
        tick();
        tick();
        rst_drv = 1'b0;
        capd.delete(); capl.delete(); gh.delete(); gt.delete();
        prev_grant = 2'b00; busy_cnt = 0; ovf_cnt = 0; ovf_tick = -1; last_tx_tick = -1; viol = 0;
    endtask

    // Runs until both queues are drained and the arbiter is back in IDLE.
    task automatic run_until_done(input string name, input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            tick_a();
            if (q0d.size() == 0 && q1d.size() == 0 && !o_busy) done = 1;
            tick_b();
            n++;
        end
        chk({name, "_completes"}, done, 1);
    endtask

    task automatic chk_cap(input string name, input int idx, input logic [7:0] d, input logic l);
        chk($sformatf("%s_byte%0d", name, idx), (idx < capd.size()) ? capd[idx] : 8'hxx, d);
        chk($sformatf("%s_last%0d", name, idx), (idx < capl.size()) ? capl[idx] : 1'bx, l);
    endtask

    vec_t tbl[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, t0, t_last;
        logic b;

        sel_m4 = 1'b0; rst_drv = 1'b1; en0 = 1'b0; en1 = 1'b0; txr_toggle = 1'b0;
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
        req0_last = 1'b0; req1_last = 1'b0; tx_ready = 1'b0; prev_grant = 2'b00;
        busy_cnt = 0; ovf_cnt = 0; viol = 0;
        repeat (2) @(negedge clk);

        // ---- req0 3-byte frame with one tx stall, req1 contending while req0 owns the port
        //              rst   v0    d0     l0    v1    d1     l1    txr  | grant  busy  txv   txd    txl   r0    r1    ovf
        tbl[0] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[2] = mk(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[3] = mk(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[4] = mk(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[5] = mk(1'b0, 1'b1, 8'hCC, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[6] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        busy_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            reset = tbl[i].rst;
            req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_last = tbl[i].l0;
            req1_valid = tbl[i].v1; req1_data = tbl[i].d1; req1_last = tbl[i].l1;
            tx_ready = tbl[i].txr;
            #1;
            chk($sformatf("vec%0d_grant", i), o_grant, tbl[i].grant);
            chk($sformatf("vec%0d_busy", i), o_busy, tbl[i].busy);
            chk($sformatf("vec%0d_tx_valid", i), o_txv, tbl[i].txv);
            if (tbl[i].txv) chk($sformatf("vec%0d_tx_data", i), o_txd, tbl[i].txd);
            chk($sformatf("vec%0d_tx_last", i), o_txl, tbl[i].txl);
            chk($sformatf("vec%0d_req0_ready", i), o_r0, tbl[i].r0);
            chk($sformatf("vec%0d_req1_ready", i), o_r1, tbl[i].r1);
            chk($sformatf("vec%0d_overflow", i), o_ovf, tbl[i].ovf);
            if (o_busy) busy_cnt++;
            @(negedge clk);
        end

        // Remaining GAP of that frame: req1 keeps requesting and must wait for IDLE.
        rst_drv = 1'b0; en0 = 1'b0; en1 = 1'b1; txr_toggle = 1'b0;
        q1d.push_back(8'h11); q1l.push_back(1'b1);
        capd.delete(); capl.delete(); gh.delete(); gt.delete(); prev_grant = 2'b00; viol = 0;
        n = 0;
        do begin
            tick_a();
            b = o_busy;
            tick_b();
            n++;
        end while (b && n < 100);
        chk("gap_ends_in_budget", (n < 100), 1);
        chk("busy_cycles_frame1", busy_cnt, 52);
        tick_a();
        chk("req1_grant_after_idle", o_grant, 2'b10);
        tick_b();
        run_until_done("req1_single", 200);
        chk("req1_single_count", capd.size(), 1);
        chk_cap("req1_single", 0, 8'h11, 1'b1);
        chk("seq1_ready_violations", viol, 0);

        // ---- Simultaneous requests after reset: req0, req1, req0, req1 with a 48-cycle gap between.
        do_reset();
        q0d = '{8'h01, 8'h02, 8'h05}; q0l = '{1'b0, 1'b1, 1'b1};
        q1d = '{8'h11, 8'h12, 8'h15}; q1l = '{1'b0, 1'b1, 1'b1};
        en0 = 1'b1; en1 = 1'b1;
        t0 = tick_n;
        run_until_done("rr", 1000);
        chk("rr_grant_count", gh.size(), 4);
        if (gh.size() == 4) begin
            chk("rr_grant0", gh[0], 2'b01);
            chk("rr_grant1", gh[1], 2'b10);
            chk("rr_grant2", gh[2], 2'b01);
            chk("rr_grant3", gh[3], 2'b10);
            chk("rr_first_grant_delay", gt[0] - t0, 1);
            chk("rr_spacing01", gt[1] - gt[0], 51);
            chk("rr_spacing12", gt[2] - gt[1], 51);
            chk("rr_spacing23", gt[3] - gt[2], 50);
        end
        chk("rr_byte_count", capd.size(), 6);
        chk_cap("rr", 0, 8'h01, 1'b0);
        chk_cap("rr", 1, 8'h02, 1'b1);
        chk_cap("rr", 2, 8'h11, 1'b0);
        chk_cap("rr", 3, 8'h12, 1'b1);
        chk_cap("rr", 4, 8'h05, 1'b1);
        chk_cap("rr", 5, 8'h15, 1'b1);
        chk("rr_ready_violations", viol, 0);

        // ---- Truncation on the MAX_FRAME_BYTES=4 instance: req1 sends 6 bytes.
        do_reset();
        sel_m4 = 1'b1;
        q1d = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        q1l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        en1 = 1'b1;
        run_until_done("trunc", 500);
        chk("trunc_byte_count", capd.size(), 4);
        chk_cap("trunc", 0, 8'h61, 1'b0);
        chk_cap("trunc", 1, 8'h62, 1'b0);
        chk_cap("trunc", 2, 8'h63, 1'b0);
        chk_cap("trunc", 3, 8'h64, 1'b1);
        chk("trunc_overflow_pulses", ovf_cnt, 1);
        chk("trunc_overflow_timing", ovf_tick - last_tx_tick, 1);
        chk("trunc_grant_count", gh.size(), 1);
        chk("trunc_ready_violations", viol, 0);
        sel_m4 = 1'b0;

        // ---- tx_ready toggling during an 8-byte req0 frame.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0d.push_back(8'h80 + 8'(i));
            q0l.push_back(i == 7);
        end
        en0 = 1'b1; txr_toggle = 1'b1;
        run_until_done("stall", 500);
        chk("stall_byte_count", capd.size(), 8);
        for (int i = 0; i < 8; i++) chk_cap("stall", i, 8'h80 + 8'(i), (i == 7));
        chk("stall_no_overflow", ovf_cnt, 0);
        chk("stall_ready_violations", viol, 0);
        txr_toggle = 1'b0;

        // ---- Reset during the 2nd byte of a req0 frame, req1 waiting afterwards.
        do_reset();
        q0d = '{8'h31, 8'h32, 8'h33, 8'h34}; q0l = '{1'b0, 1'b0, 1'b0, 1'b1};
        en0 = 1'b1;
        n = 0;
        while (capd.size() < 1 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_first_byte_seen", capd.size(), 1);
        rst_drv = 1'b1;
        tick();
        rst_drv = 1'b0; en0 = 1'b0; q0d.delete(); q0l.delete();
        q1d = '{8'h41, 8'h42}; q1l = '{1'b0, 1'b1};
        en1 = 1'b1;
        tick_a();
        chk("rst_after_grant", o_grant, 2'b00);
        chk("rst_after_busy", o_busy, 1'b0);
        chk("rst_after_tx_valid", o_txv, 1'b0);
        chk("rst_after_tx_last", o_txl, 1'b0);
        chk("rst_after_req0_ready", o_r0, 1'b0);
        chk("rst_after_req1_ready", o_r1, 1'b0);
        chk("rst_after_overflow", o_ovf, 1'b0);
        tick_b();
        tick_a();
        chk("rst_req1_granted", o_grant, 2'b10);
        chk("rst_req1_busy", o_busy, 1'b1);
        tick_b();
        run_until_done("rst", 300);
        chk("rst_byte_count", capd.size(), 3);
        chk_cap("rst", 0, 8'h31, 1'b0);
        chk_cap("rst", 1, 8'h41, 1'b0);
        chk_cap("rst", 2, 8'h42, 1'b1);
        chk("rst_ready_violations", viol, 0);

        // ---- req0 raises a new frame during the GAP of its previous one.
        do_reset();
        q0d = '{8'h51}; q0l = '{1'b1};
        en0 = 1'b1;
        n = 0;
        while (capd.size() < 1 && n < 20) begin
            tick();
            n++;
        end
        chk("gapreq_first_frame", capd.size(), 1);
        t_last = last_tx_tick;
        q0d.push_back(8'h52); q0l.push_back(1'b1);
        run_until_done("gapreq", 300);
        chk("gapreq_grant_count", gh.size(), 2);
        if (gh.size() == 2) chk("gapreq_grant_delay", gt[1] - t_last, 50);
        chk("gapreq_busy_cycles", busy_cnt, 98);
        chk_cap("gapreq", 1, 8'h52, 1'b1);
        chk("gapreq_ready_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter: IFG_CYCLES, default 48; clk cycles of enforced idle between frames (96 bit times at RMII 50 MHz).
REQ-002 Parameter: MAX_FRAME_BYTES, default 1518; byte limit per granted frame before forced truncation.
REQ-003 Port: clk  in  1  single 50 MHz clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Ports: req0_data / req1_data  in  8  requester byte streams.
REQ-006 Ports: req0_valid / req1_valid  in  1  requester byte valid.
REQ-007 Ports: req0_last / req1_last  in  1  marks final byte of requester frame.
REQ-008 Ports: req0_ready / req1_ready  out  1  byte accepted from requester when valid&ready.
REQ-009 Port: tx_data  out  8  byte to downstream TX frame builder.
REQ-010 Port: tx_valid  out  1  tx_data valid.
REQ-011 Port: tx_last  out  1  final byte of outgoing frame.
REQ-012 Port: tx_ready  in  1  downstream accepts byte when tx_valid&tx_ready.
REQ-013 Port: grant  out  2  registered one-hot owner ({0,1}=req0, {1,0}=req1, 00=none).
REQ-014 Port: busy  out  1  high in any state except IDLE.
REQ-015 Port: overflow_err  out  1  one-cycle pulse on truncation.

Function
REQ-016 States SHALL be IDLE, XFER, DRAIN, GAP.
REQ-017 IDLE: if exactly one reqN_valid high, grant it; if both, grant the requester not served last; next state XFER.
REQ-018 Round-robin pointer SHALL update on entry to XFER; reset value makes req0 win the first contention.
REQ-019 Grant decision SHALL be registered: request first seen in IDLE at cycle N -> grant and XFER at N+1; no ready asserted at N.
REQ-020 XFER: tx_data/tx_valid/tx_last SHALL combinationally follow the granted requester; granted ready = tx_ready; ungranted ready = 0.
REQ-021 A 11-bit byte counter SHALL clear on XFER entry and increment per tx handshake.
REQ-022 Handshake with granted last=1 -> GAP; a frame of one byte is legal.
REQ-023 Handshake where counter reaches MAX_FRAME_BYTES without last -> tx_last forced 1 on that byte, overflow_err pulsed next cycle, next state DRAIN.
REQ-024 DRAIN: tx_valid=0; granted ready=1; bytes discarded until handshake with last=1 -> GAP.
REQ-025 GAP: all ready=0, tx_valid=0; counter loads IFG_CYCLES-1 on entry, decrements; at 0 -> IDLE; exactly IFG_CYCLES cycles in GAP.
REQ-026 grant SHALL remain constant from XFER entry through DRAIN; cleared to 00 on GAP entry.
REQ-027 Requester deasserting valid mid-frame SHALL stall XFER (tx_valid=0), no timeout.
REQ-028 A requester SHALL never see ready while not granted; requests arriving during GAP are held off until IDLE.
REQ-029 tx_ready low SHALL hold counter and state; no byte lost or duplicated.

Reset
REQ-030 reset SHALL take priority over all events: state IDLE, grant=00, busy=0, overflow_err=0, tx_valid=0, tx_last=0, req ready=0, counters 0, pointer favours req0.
REQ-031 Reset mid-frame SHALL abandon the frame with no tx_last emitted; downstream handles truncation.
REQ-032 First cycle after reset deassertion SHALL be IDLE and able to grant.

Verification
REQ-033 Single req0 3-byte frame 0xAA,0xBB,0xCC(last), tx_ready=1 -> grant=01 one cycle after valid, three tx bytes, tx_last on 0xCC, busy high for 3+48 cycles after grant.
REQ-034 Both valid simultaneously after reset -> req0 served first, then after 48-cycle GAP req1 granted; third contention favours req0 again.
REQ-035 MAX_FRAME_BYTES=4, req1 sends 6 bytes -> tx gets 4 bytes with tx_last on 4th, overflow_err one pulse, bytes 5-6 absorbed with req1_ready=1, tx_valid=0.
REQ-036 tx_ready toggled 1/0 during req0 8-byte frame -> exact 8-byte sequence out, counter and state frozen on stalls.
REQ-037 Reset asserted on 2nd byte of req0 frame -> next cycle all outputs at reset values; req1 pending then granted one cycle after reset release.
REQ-038 req0 valid raised during GAP -> req0_ready=0 until GAP ends; grant one cycle after IDLE entry.
